// File: rtl/core_ex_regfile_sb_if.sv
// Register file / scoreboard bus bundle.
// The master side is the pipeline (read indices, writebacks, issue, flush);
// the slave side is the register file returning read data, busy flags and
// the busy-register count.
interface core_ex_regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5,
    parameter int NRD   = 2,
    parameter int CNT_W = 6
);
    logic [NRD*IDX_W-1:0] rd_idx;
    logic [NRD*XLEN-1:0]  rd_dat;
    logic [NRD-1:0]       rd_busy;

    logic                 wb0_wen;
    logic [IDX_W-1:0]     wb0_idx;
    logic [XLEN-1:0]      wb0_dat;

    logic                 wb1_wen;
    logic [IDX_W-1:0]     wb1_idx;
    logic [XLEN-1:0]      wb1_dat;

    logic                 iss_vld;
    logic [IDX_W-1:0]     iss_idx;

    logic                 flush;
    logic [CNT_W-1:0]     busy_cnt;

    modport master (
        output rd_idx,
        input  rd_dat,
        input  rd_busy,
        output wb0_wen,
        output wb0_idx,
        output wb0_dat,
        output wb1_wen,
        output wb1_idx,
        output wb1_dat,
        output iss_vld,
        output iss_idx,
        output flush,
        input  busy_cnt
    );

    modport slave (
        input  rd_idx,
        output rd_dat,
        output rd_busy,
        input  wb0_wen,
        input  wb0_idx,
        input  wb0_dat,
        input  wb1_wen,
        input  wb1_idx,
        input  wb1_dat,
        input  iss_vld,
        input  iss_idx,
        input  flush,
        output busy_cnt
    );
endinterface

// File: rtl/core_ex_regfile_sb.sv
// Execute-stage register file with a per-register busy scoreboard.
// x0 has no storage: it always reads 0, ignores writes and is never busy.
// Two writeback ports (wb0 = ALU, wb1 = LSU); wb1 wins on an index clash.
// busy_cnt tracks the number of busy registers incrementally and cannot wrap
// because at most RF_NUM-1 bits can ever be set.
// Optional feature: define CORE_RF_BYPASS_EN to forward same-cycle writeback
// data (and the cleared busy state) straight to the read ports. Without it the
// read ports see registered state only.
module core_ex_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int RF_NUM = 32,
    parameter int IDX_W  = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 6
) (
    input logic               clk,
    input logic               rst_n,
    core_ex_regfile_sb_if.slave bus
);

    // Architectural storage, x1..x(RF_NUM-1) only.
    logic [XLEN-1:0]   rf_q [1:RF_NUM-1];
    logic [XLEN-1:0]   rf_d [1:RF_NUM-1];

    // Scoreboard; bit 0 is never set because no mask ever touches it.
    logic [RF_NUM-1:0] busy_q;
    logic [RF_NUM-1:0] busy_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Qualified write / issue strobes (index 0 is a no-op target).
    logic              wb0_act;
    logic              wb1_act;
    logic              iss_act;

    logic [RF_NUM-1:0] set_mask;
    logic [RF_NUM-1:0] clr_mask;
    logic [RF_NUM-1:0] new_set;
    logic [RF_NUM-1:0] dropped;
    logic [CNT_W-1:0]  inc;
    logic [CNT_W-1:0]  dec;

    logic [NRD*XLEN-1:0] rd_dat_c;
    logic [NRD-1:0]      rd_busy_c;
    logic [IDX_W-1:0]    rd_sel;
    logic [XLEN-1:0]     rd_val;
    logic                rd_bsy;

    assign wb0_act = bus.wb0_wen && (bus.wb0_idx != '0);
    assign wb1_act = bus.wb1_wen && (bus.wb1_idx != '0);
    assign iss_act = bus.iss_vld && (bus.iss_idx != '0);

    // Next register contents: wb1 is applied last so it wins a same-index clash.
    always_comb begin
        rf_d = rf_q;
        if (wb0_act) begin
            rf_d[bus.wb0_idx] = bus.wb0_dat;
        end
        if (wb1_act) begin
            rf_d[bus.wb1_idx] = bus.wb1_dat;
        end
    end

    // One-hot set/clear requests for the scoreboard this cycle.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_act) begin
            set_mask[bus.iss_idx] = 1'b1;
        end
        if (wb0_act) begin
            clr_mask[bus.wb0_idx] = 1'b1;
        end
        if (wb1_act) begin
            clr_mask[bus.wb1_idx] = 1'b1;
        end
    end

    // Next busy bits and count: set beats clear, flush beats everything.
    always_comb begin
        new_set = set_mask & ~busy_q;
        dropped = busy_q & clr_mask & ~set_mask;
        inc     = '0;
        dec     = '0;
        for (int i = 0; i < RF_NUM; i++) begin
            inc = inc + CNT_W'(new_set[i]);
            dec = dec + CNT_W'(dropped[i]);
        end
        if (bus.flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            busy_d = (busy_q & ~clr_mask) | set_mask;
            cnt_d  = cnt_q + inc - dec;
        end
    end

    // Combinational read ports, optionally forwarding same-cycle writebacks.
    always_comb begin
        rd_dat_c  = '0;
        rd_busy_c = '0;
        rd_sel    = '0;
        rd_val    = '0;
        rd_bsy    = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            rd_sel = bus.rd_idx[k*IDX_W +: IDX_W];
            rd_val = '0;
            if (rd_sel != '0) begin
                rd_val = rf_q[rd_sel];
            end
            rd_bsy = busy_q[rd_sel];
`ifdef CORE_RF_BYPASS_EN
            if (wb1_act && (bus.wb1_idx == rd_sel)) begin
                rd_val = bus.wb1_dat;
                rd_bsy = iss_act && (bus.iss_idx == rd_sel);
            end else if (wb0_act && (bus.wb0_idx == rd_sel)) begin
                rd_val = bus.wb0_dat;
                rd_bsy = iss_act && (bus.iss_idx == rd_sel);
            end
`else
`endif
            rd_dat_c[k*XLEN +: XLEN] = rd_val;
            rd_busy_c[k]             = rd_bsy;
        end
    end

    assign bus.rd_dat   = rd_dat_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = cnt_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < RF_NUM; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
